// File: rtl/execute_lane.sv
// execute_lane: forwarding operand select, single-cycle ALU and iterative mul/div into the E/M register.
// Define EXEC_DIV_EN to build the restoring divider; otherwise DIV ops complete at once flagged illegal.
module execute_lane #(
    parameter int WIDTH = 32,
    parameter int NFWD  = 4,
    parameter int FSELW = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [2:0]            alucontrol,
    input  logic                  sign,
    input  logic                  mdsel,
    input  logic [1:0]            mdop,
    input  logic                  alusrc,
    input  logic                  regdst,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [WIDTH-1:0]      signimm,
    input  logic [WIDTH-1:0]      rd1,
    input  logic [WIDTH-1:0]      rd2,
    input  logic [NFWD*WIDTH-1:0] fwd_data,
    input  logic [FSELW-1:0]      forwarda,
    input  logic [FSELW-1:0]      forwardb,
    output logic                  busy,
    output logic                  valid_out,
    output logic [WIDTH-1:0]      solution,
    output logic [WIDTH-1:0]      writedata,
    output logic [4:0]            writereg,
    output logic                  zero,
    output logic                  illegal
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] srca, fwdb, srcb, alu_res, short_res, mag_a, mag_b_in, bmag, wdata_h, mul_res, md_res;
    logic [2*WIDTH-1:0] acc, acc_next, mul_next, prod;
    logic [WIDTH:0] mul_sum;
    logic [4:0] wreg, wreg_h;
    logic nega, negb, hi_sel, md_long, ill;

    function automatic logic [WIDTH-1:0] pick(input logic [FSELW-1:0] fs, input logic [WIDTH-1:0] base);
        pick = (fs == '0) ? base : '0;
        for (int k = 0; k < NFWD; k++)
            if (fs == FSELW'(k + 1)) pick = fwd_data[k*WIDTH +: WIDTH];
    endfunction

    assign srca      = pick(forwarda, rd1);
    assign fwdb      = pick(forwardb, rd2);
    assign srcb      = alusrc ? signimm : fwdb;
    assign wreg      = regdst ? rd : rt;
    assign mag_a     = (sign & srca[WIDTH-1]) ? -srca : srca;
    assign mag_b_in  = (sign & srcb[WIDTH-1]) ? -srcb : srcb;
    assign short_res = mdsel ? '0 : alu_res;

    always_comb begin
        case (alucontrol)
            3'b000:  alu_res = srca & srcb;
            3'b001:  alu_res = srca | srcb;
            3'b010:  alu_res = srca + srcb;
            3'b011:  alu_res = ~(srca | srcb);
            3'b100:  alu_res = srca ^ srcb;
            3'b101:  alu_res = srca << srcb[4:0];
            3'b110:  alu_res = srca - srcb;
            default: alu_res = {{(WIDTH-1){1'b0}}, sign ? ($signed(srca) < $signed(srcb)) : (srca < srcb)};
        endcase
    end

    // Shift-add on magnitudes: multiplier sits in the low half and drains out as the product fills in.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bmag} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign prod     = (nega ^ negb) ? -mul_next : mul_next;
    assign mul_res  = hi_sel ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];

`ifdef EXEC_DIV_EN
    logic [WIDTH:0] rem_try;
    logic [WIDTH-1:0] rem_sub, quo, rem, div_res;
    logic [2*WIDTH-1:0] div_next;
    logic ge;
    // Restoring step: remainder in the high half, dividend shifts out of the low half as quotient bits shift in.
    assign rem_try  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign ge       = rem_try >= {1'b0, bmag};
    assign rem_sub  = rem_try[WIDTH-1:0] - bmag;
    assign div_next = {ge ? rem_sub : rem_try[WIDTH-1:0], acc[WIDTH-2:0], ge};
    assign quo      = div_next[WIDTH-1:0];
    assign rem      = div_next[2*WIDTH-1:WIDTH];
    assign div_res  = hi_sel ? (nega ? -rem : rem) : (bmag == '0) ? '1 : ((nega ^ negb) ? -quo : quo);
    assign acc_next = (state == DIV) ? div_next : mul_next;
    assign md_res   = (state == DIV) ? div_res : mul_res;
    assign md_long  = mdsel;
    assign ill      = 1'b0;
`else
    assign acc_next = mul_next;
    assign md_res   = mul_res;
    assign md_long  = mdsel & ~mdop[1];
    assign ill      = mdsel & mdop[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE; count <= '0; acc <= '0; bmag <= '0; nega <= 1'b0; negb <= 1'b0; hi_sel <= 1'b0;
            wreg_h <= '0; wdata_h <= '0; busy <= 1'b0; valid_out <= 1'b0; solution <= '0;
            writedata <= '0; writereg <= '0; zero <= 1'b0; illegal <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (flush) begin
                state <= IDLE; busy <= 1'b0; count <= '0;
            end else if (state == IDLE) begin
                if (valid_in & md_long) begin
                    state <= mdop[1] ? DIV : MUL; busy <= 1'b1; count <= '0;
                    acc <= {{WIDTH{1'b0}}, mag_a}; bmag <= mag_b_in;
                    nega <= sign & srca[WIDTH-1]; negb <= sign & srcb[WIDTH-1];
                    hi_sel <= mdop[0]; wreg_h <= wreg; wdata_h <= fwdb;
                end else if (valid_in) begin
                    valid_out <= 1'b1; solution <= short_res; zero <= short_res == '0;
                    illegal <= ill; writedata <= fwdb; writereg <= wreg;
                end
            end else begin
                acc <= acc_next; count <= count + 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    state <= IDLE; busy <= 1'b0; count <= '0; valid_out <= 1'b1;
                    solution <= md_res; zero <= md_res == '0; illegal <= 1'b0;
                    writedata <= wdata_h; writereg <= wreg_h;
                end
            end
        end
    end
endmodule

// File: doc/execute_lane.md
# execute_lane

Parametrised single-lane execute stage for the superscalar pipeline; one instance per issue slot. It selects operands from the register-read value or any of NFWD forwarding sources and performs single-cycle ALU operations. Multiply and divide run on an iterative shift-add/restoring unit with a busy/stall handshake. All results are registered into the lane's E/M output register.

## Interface
Parameters:
- WIDTH, 32, datapath width (even, ≥8)
- NFWD, 4, number of forwarding sources
- FSELW, 3, forward-select width, ≥ clog2(NFWD+1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous squash of held/in-flight op
- valid_in  in  1  op present this cycle
- alucontrol  in  3  ALU op: 000 AND, 001 OR, 010 ADD, 011 NOR, 100 XOR, 101 SLL, 110 SUB, 111 SLT
- sign  in  1  signed SLT / mul / div
- mdsel  in  1  op is multi-cycle (uses mdop, ignores alucontrol)
- mdop  in  2  00 MUL low, 01 MUL high, 10 DIV quotient, 11 DIV remainder
- alusrc  in  1  B operand = signimm
- regdst  in  1  dest = rd else rt
- rt, rd  in  5  register specifiers
- signimm, rd1, rd2  in  WIDTH  immediate, register-read A/B
- fwd_data  in  NFWD*WIDTH  source k at bits [k*WIDTH +: WIDTH]
- forwarda, forwardb  in  FSELW  0 = rd1/rd2, k = fwd_data source k-1
- busy  out  1  lane stalled; upstream holds op
- valid_out  out  1  solution/writereg valid
- solution  out  WIDTH  registered result
- writedata  out  WIDTH  registered forwarded B (store data)
- writereg  out  5  registered destination
- zero  out  1  registered (ALU result == 0)
- illegal  out  1  registered, op not supported by build

## Operation
- srca = forwarda ? fwd_data[forwarda-1] : rd1; fwdb likewise from rd2; srcb = alusrc ? signimm : fwdb. Select > NFWD → 0.
- SLL shifts srca by srcb[4:0]; SLT compares signed when sign=1, else unsigned, result 0/1 zero-extended; ADD/SUB wrap, no overflow trap.
- Accept = valid_in & !busy & !flush. Inputs while busy are ignored.
- FSM: IDLE, MUL, DIV. ALU accept stays IDLE, loads output register. mdsel accept latches srca, srcb, mdop, sign, writereg, writedata; enters MUL (mdop[1]=0) or DIV; count = 0.
- MUL: magnitudes when sign=1; one shift-add per cycle into 2·WIDTH accumulator; on final iteration negate if operand signs differ; output low or high half per mdop.
- DIV: restoring, one quotient bit per cycle on magnitudes; quotient negated if signs differ, remainder takes dividend sign. Divisor 0: quotient all ones, remainder = dividend. Most-negative ÷ −1: quotient = most-negative, remainder 0.
- flush: FSM → IDLE, valid_out 0 next cycle, partial result discarded.

## Timing
- Reset: busy, valid_out, solution, writedata, writereg, zero, illegal all 0; FSM IDLE; count 0.
- ALU op accepted in cycle n → valid_out, solution in cycle n+1; back-to-back ops every cycle.
- md op accepted in cycle n → busy=1 cycles n+1..n+WIDTH; valid_out=1 for exactly cycle n+WIDTH+1, busy=0 then, new op acceptable that cycle.
- valid_out is a one-cycle pulse per completed op; solution holds until next completion.
- flush and valid_in together: flush wins, nothing accepted.
- reset mid-operation: immediate return to reset values.

## Configuration
- EXEC_DIV_EN defined: DIV state and restoring divider built as above.
- Undefined: no divider logic; mdsel with mdop[1]=1 completes like an ALU op (cycle n+1, no busy), solution = 0, illegal = 1 for that pulse. MUL unaffected.

## Test plan
- ALU forwarding, NFWD=4: rd1=5, fwd source 2 = 7, forwarda=3, forwardb=0, rd2=9, ADD → next cycle solution=16, valid_out=1, zero=0.
- Signed SLT: srca=0xFFFFFFFF, srcb=1, sign=1 → 1; sign=0 → 0.
- Signed MUL high: −3 × 5, mdop=01 → busy 32 cycles, then solution=0xFFFFFFFF; mdop=00 → 0xFFFFFFF1 at cycle n+33.
- DIV (EXEC_DIV_EN): −7 ÷ 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 9 ÷ 0 → quotient 0xFFFFFFFF, remainder 9.
- flush in cycle n+10 of MUL → busy 0 at n+11, no valid_out pulse; following ADD accepted normally.
- Build without EXEC_DIV_EN: DIV op → cycle n+1 solution=0, illegal=1, busy never set.
